// File: rtl/sram_ctrl_pkg.sv
// Shared widths, wait-counter width and FSM state encoding for the
// asynchronous SRAM controller.
package sram_ctrl_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_e;

    // Counter load value for a phase lasting `cycles` clocks: the phase ends
    // on the edge where the counter is already zero.
    function automatic logic [CNT_W-1:0] wait_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-access asynchronous SRAM controller: one read or write at a time,
// fully registered external strobes, fixed strobe lengths set by parameters.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_data_write,
    input  logic              sram_cs,
    input  logic              sram_we,
    input  logic [BE_W-1:0]   sram_bin,
    output logic              sram_ready,
    output logic [DATA_W-1:0] sram_data_out,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dq_o,
    output logic              ram_dq_oe,
    input  logic [DATA_W-1:0] ram_dq_i,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [BE_W-1:0]   ram_be_n
);

    localparam logic [CNT_W-1:0] RD_LOAD = wait_load(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD = wait_load(WR_WAIT);

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                ready_q,    ready_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   dq_o_q,     dq_o_d;
    logic                dq_oe_q,    dq_oe_d;
    logic                ce_n_q,     ce_n_d;
    logic                oe_n_q,     oe_n_d;
    logic                we_n_q,     we_n_d;
    logic [BE_W-1:0]     be_n_q,     be_n_d;

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so every pad-facing signal comes straight from a flop.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        state_d    = state_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        ready_d    = ready_q;
        data_out_d = data_out_q;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = dq_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        be_n_d     = be_n_q;

        unique case (state_q)
            IDLE: begin
                if (sram_cs) begin
                    addr_d  = sram_addr;
                    ce_n_d  = 1'b0;
                    ready_d = 1'b0;
                    if (sram_we) begin
                        state_d = WR_SETUP;
                        cnt_d   = '0;
                        dq_o_d  = sram_data_write;
                        be_n_d  = ~sram_bin;
                    end else begin
                        state_d = READ;
                        cnt_d   = RD_LOAD;
                        oe_n_d  = 1'b0;
                        be_n_d  = '0;
                    end
                end
            end

            READ: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    data_out_d = ram_dq_i;
                    ready_d    = 1'b1;
                    ce_n_d     = 1'b1;
                    oe_n_d     = 1'b1;
                    be_n_d     = '1;
                end
            end

            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = WR_LOAD;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end

            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                    we_n_d  = 1'b1;
                end
            end

            WR_HOLD: begin
                state_d = IDLE;
                ready_d = 1'b1;
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                be_n_d  = '1;
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                be_n_d  = '1;
            end
        endcase
    end

    // Asynchronous reset drops every strobe at once, aborting any access.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops
        // update together from values sampled before the edge.
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            data_out_q <= '0;
            addr_q     <= '0;
            dq_o_q     <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            data_out_q <= data_out_d;
            addr_q     <= addr_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
        end
    end

    assign sram_ready    = ready_q;
    assign sram_data_out = data_out_q;
    assign ram_addr      = addr_q;
    assign ram_dq_o      = dq_o_q;
    assign ram_dq_oe     = dq_oe_q;
    assign ram_ce_n      = ce_n_q;
    assign ram_oe_n      = oe_n_q;
    assign ram_we_n      = we_n_q;
    assign ram_be_n      = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed vector table, corner-case
// sequences and random traffic against a transaction-level memory model.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (default timing) ----------------
    logic              rst;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data_write;
    logic              sram_cs, sram_we;
    logic [BE_W-1:0]   sram_bin;
    logic              sram_ready;
    logic [DATA_W-1:0] sram_data_out;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dq_o, ram_dq_i;
    logic              ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n;
    logic [BE_W-1:0]   ram_be_n;

    sram_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) u_dut (
        .clk(clk), .rst(rst),
        .sram_addr(sram_addr), .sram_data_write(sram_data_write),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_bin(sram_bin),
        .sram_ready(sram_ready), .sram_data_out(sram_data_out),
        .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe),
        .ram_dq_i(ram_dq_i), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .ram_be_n(ram_be_n)
    );

    // ---------------- DUT B (RD_WAIT=1, WR_WAIT=15) ----------------
    logic              rst_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b, data_out_b, dq_o_b, dq_i_b;
    logic              cs_b, we_b, ready_b, dq_oe_b, ce_n_b, oe_n_b, we_n_b;
    logic [BE_W-1:0]   bin_b, be_n_b;
    logic [ADDR_W-1:0] ram_addr_b;

    sram_ctrl #(.RD_WAIT(1), .WR_WAIT(15)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .sram_addr(addr_b), .sram_data_write(wdata_b),
        .sram_cs(cs_b), .sram_we(we_b), .sram_bin(bin_b),
        .sram_ready(ready_b), .sram_data_out(data_out_b),
        .ram_addr(ram_addr_b), .ram_dq_o(dq_o_b), .ram_dq_oe(dq_oe_b),
        .ram_dq_i(dq_i_b), .ram_ce_n(ce_n_b), .ram_oe_n(oe_n_b),
        .ram_we_n(we_n_b), .ram_be_n(be_n_b)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    int overlap  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural SRAM chip seen by DUT A, and the expected memory contents
    // derived from the sequence of issued transactions.
    logic [DATA_W-1:0] sram_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] last_rd;

    always @(negedge clk) begin
        if (!ram_ce_n && !ram_oe_n && sram_mem.exists(ram_addr))
            ram_dq_i = sram_mem[ram_addr];
        else
            ram_dq_i = 32'h0BAD_F00D;
        if (!ram_ce_n && !ram_we_n && ram_dq_oe) begin
            if (!sram_mem.exists(ram_addr)) sram_mem[ram_addr] = '0;
            for (int i = 0; i < BE_W; i++)
                if (!ram_be_n[i]) sram_mem[ram_addr][8*i +: 8] = ram_dq_o[8*i +: 8];
        end
        if (rst && ram_dq_oe && !ram_oe_n) overlap++;
    end

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0] bin);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++)
            if (bin[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // One complete access on DUT A, entered and left at posedge+1 with ready=1.
    // With `hammer` set, cs stays high with a conflicting write request for
    // the whole busy period.
    task automatic do_access(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data, input logic [BE_W-1:0] bin,
                             input logic [BE_W-1:0] exp_be, input bit hammer);
        int busy, oe_lo, we_lo, oe_hi;
        bit addr_ok, be_ok, dq_ok;
        busy = 0; oe_lo = 0; we_lo = 0; oe_hi = 0;
        addr_ok = 1; be_ok = 1; dq_ok = 1;
        sram_cs = 1'b1; sram_we = we; sram_addr = addr;
        sram_data_write = data; sram_bin = bin;
        @(posedge clk); #1;
        if (hammer) begin
            sram_we = 1'b1; sram_addr = addr ^ 22'h1;
            sram_data_write = ~data; sram_bin = 4'hF;
        end else begin
            sram_cs = 1'b0;
        end
        while (!sram_ready && busy < 64) begin
            busy++;
            if (!ram_oe_n) oe_lo++;
            if (!ram_we_n) we_lo++;
            if (ram_dq_oe) oe_hi++;
            if (ram_addr !== addr) addr_ok = 0;
            if (ram_be_n !== exp_be) be_ok = 0;
            if (we && ram_dq_o !== data) dq_ok = 0;
            @(posedge clk); #1;
        end
        sram_cs = 1'b0;
        check({tag, "_busy"},  busy,  we ? WR_WAIT + 2 : RD_WAIT);
        check({tag, "_oe_lo"}, oe_lo, we ? 0 : RD_WAIT);
        check({tag, "_we_lo"}, we_lo, we ? WR_WAIT : 0);
        check({tag, "_dq_oe"}, oe_hi, we ? WR_WAIT + 1 : 0);
        check({tag, "_stable"}, {addr_ok, be_ok, dq_ok}, 3'b111);
        check({tag, "_idle_strobes"}, {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, ram_dq_oe},
              {1'b1, 1'b1, 1'b1, 4'hF, 1'b0});
        if (we) begin
            ref_mem[addr] = merge(ref_mem.exists(addr) ? ref_mem[addr] : '0, data, bin);
        end else begin
            last_rd = ref_mem[addr];
        end
        check({tag, "_data_out"}, sram_data_out, last_rd);
        if (hammer) begin
            @(posedge clk); #1;
            check({tag, "_no_queued"}, {sram_ready, ram_ce_n}, 2'b11);
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   bin;
        logic [BE_W-1:0]   exp_be;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;

    vec_t vecs[7];
    logic [ADDR_W-1:0] pool[6];

    initial begin
        int k;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [BE_W-1:0]   b;
        logic              w;

        rst = 1'b0; rst_b = 1'b0;
        sram_cs = 0; sram_we = 0; sram_addr = '0; sram_data_write = '0; sram_bin = '0;
        cs_b = 0; we_b = 0; addr_b = '0; wdata_b = '0; bin_b = '0; dq_i_b = 32'h5A5A_0001;
        last_rd = '0;

        vecs[0] = '{1'b0, 22'h000123, 32'h0,         4'h5, 4'h0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 22'h3FFFFF, 32'hA5A5_5A5A, 4'h5, 4'hA, 32'h0};
        vecs[2] = '{1'b0, 22'h3FFFFF, 32'h0,         4'hF, 4'h0, 32'h11A5_335A};
        vecs[3] = '{1'b1, 22'h000200, 32'hCAFE_F00D, 4'h0, 4'hF, 32'h0};
        vecs[4] = '{1'b0, 22'h000200, 32'h0,         4'h0, 4'h0, 32'h0123_4567};
        vecs[5] = '{1'b1, 22'h000200, 32'hFF00_0000, 4'h8, 4'h7, 32'h0};
        vecs[6] = '{1'b0, 22'h000200, 32'h0,         4'h3, 4'h0, 32'hFF23_4567};

        sram_mem[22'h000123] = 32'hDEAD_BEEF; ref_mem[22'h000123] = 32'hDEAD_BEEF;
        sram_mem[22'h3FFFFF] = 32'h1122_3344; ref_mem[22'h3FFFFF] = 32'h1122_3344;
        sram_mem[22'h000200] = 32'h0123_4567; ref_mem[22'h000200] = 32'h0123_4567;

        pool = '{22'h000000, 22'h3FFFFF, 22'h0ABCDE, 22'h155555, 22'h2AAAAA, 22'h000001};
        foreach (pool[i]) begin
            if (!ref_mem.exists(pool[i])) begin
                d = $urandom;
                sram_mem[pool[i]] = d; ref_mem[pool[i]] = d;
            end
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", {sram_ready, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, ram_dq_oe},
              {1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0});
        check("reset_regs", {sram_data_out, ram_addr, ram_dq_o}, '0);

        // Release reset away from an edge; the first request lands on the
        // very next rising edge.
        @(negedge clk); rst = 1'b1; rst_b = 1'b1;

        // Directed vectors; consecutive entries are issued back to back.
        for (int i = 0; i < 7; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                      vecs[i].bin, vecs[i].exp_be, 1'b0);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), sram_data_out, vecs[i].exp_rd);
        end

        // cs held high with a conflicting write throughout a read.
        do_access("hammer", 1'b0, 22'h000123, 32'h1357_9BDF, 4'hF, 4'h0, 1'b1);
        check("hammer_no_write", sram_mem.exists(22'h000122), 1'b0);
        check("hammer_rdata", sram_data_out, 32'hDEAD_BEEF);

        // Reset asserted during the write pulse.
        sram_cs = 1'b1; sram_we = 1'b1; sram_addr = 22'h0ABCDE;
        sram_data_write = 32'h7777_8888; sram_bin = 4'hF;
        @(posedge clk); #1;
        sram_cs = 1'b0;
        k = 0;
        while (ram_we_n && k < 8) begin @(posedge clk); #1; k++; end
        check("rst_reached_pulse", ram_we_n, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rst_abort_strobes", {ram_we_n, ram_dq_oe, sram_ready, ram_ce_n, ram_oe_n, ram_be_n},
              {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF});
        check("rst_abort_regs", {sram_data_out, ram_addr, ram_dq_o}, '0);
        last_rd = '0;
        @(negedge clk); rst = 1'b1;
        do_access("post_rst_wr", 1'b1, 22'h0ABCDE, 32'h2468_ACE0, 4'hF, 4'h0, 1'b0);
        do_access("post_rst_rd", 1'b0, 22'h0ABCDE, 32'h0, 4'h0, 4'h0, 1'b0);
        check("post_rst_rdata", sram_data_out, 32'h2468_ACE0);

        // Random traffic over a small address pool.
        for (int i = 0; i < 150; i++) begin
            a = pool[$urandom_range(0, 5)];
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            do_access($sformatf("rnd%0d", i), w, a, d, b, w ? ~b : 4'h0, 1'b0);
        end

        check("oe_dq_overlap", overlap, 0);

        // DUT B: shortest read, longest write.
        cs_b = 1'b1; we_b = 1'b0; addr_b = 22'h000015;
        @(posedge clk); #1;
        cs_b = 1'b0;
        k = 0;
        while (!ready_b && k < 64) begin k++; @(posedge clk); #1; end
        check("b_read_busy", k, 1);
        check("b_read_data", data_out_b, 32'h5A5A_0001);

        cs_b = 1'b1; we_b = 1'b1; addr_b = 22'h000016; wdata_b = 32'hC3C3_3C3C; bin_b = 4'h6;
        @(posedge clk); #1;
        cs_b = 1'b0;
        k = 0; a = '0;
        begin
            int wl;
            wl = 0;
            while (!ready_b && k < 64) begin
                k++;
                if (!we_n_b) wl++;
                @(posedge clk); #1;
            end
            check("b_write_busy", k, 17);
            check("b_write_we_lo", wl, 15);
        end
        check("b_write_keeps_data", data_out_b, 32'h5A5A_0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
